// File: rtl/even_odd_pkg.sv
// even_odd_pkg: shared parity codes and FSM state encoding
// for the even/odd number generator.
package even_odd_pkg;

  localparam logic EVEN = 1'b1;
  localparam logic ODD  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/even_odd_gen_parity_align.sv
// parity_align: combinational first-value aligner.
// Ports: start (raw start value), parity (1=EVEN, 0=ODD), first (aligned value).
module parity_align #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] start,
  input  logic             parity,
  output logic [WIDTH-1:0] first
);

  // EVEN (1) wants bit0 = 0, ODD (0) wants bit0 = 1,
  // so bit0 differing from the parity code means already aligned.
  assign first = (start[0] ^ parity) ? start : start + WIDTH'(1);

endmodule

// File: rtl/even_odd_gen.sv
// even_odd_gen: emits count numbers of a requested parity, stepping by 2.
// Ports: req_* request handshake, out_* output stream, busy while running.
module even_odd_gen
  import even_odd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_parity,
  input  logic [WIDTH-1:0] req_start,
  input  logic [CNT_W-1:0] req_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_number,
  output logic             out_last,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] first;

  parity_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .start  (req_start),
    .parity (req_parity),
    .first  (first)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);
  assign out_last  = (state == RUN) &&
                     (remaining == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_number <= '0;
      remaining  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Zero-count requests are accepted but start nothing.
          if (req_valid && (req_count != '0)) begin
            state      <= RUN;
            out_number <= first;
            remaining  <= req_count;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (remaining == CNT_W'(1)) begin
              state <= IDLE;
            end else begin
              out_number <= out_number + WIDTH'(2);
              remaining  <= remaining - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_even_odd_gen.sv
// tb_even_odd_gen: directed scoreboard bench for even_odd_gen.
// Expected numbers are queued at request time and popped on each transfer.
module tb_even_odd_gen;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] num;
    logic             last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_parity;
  logic [WIDTH-1:0] req_start;
  logic [CNT_W-1:0] req_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_number;
  logic             out_last;
  logic             busy;

  int   tests;
  int   failed;
  int   xfers;
  exp_t q[$];

  even_odd_gen #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_parity (req_parity),
    .req_start  (req_start),
    .req_count  (req_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_number (out_number),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor at the negedge, then advance past the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      xfers++;
      if (q.size() == 0) begin
        tests++;
        failed++;
        $error("FAIL unexpected_out: got %0h expected none", out_number);
      end else begin
        e = q.pop_front();
        chk("out_number", 32'(out_number), 32'(e.num));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic par,
                         input logic [WIDTH-1:0] start,
                         input logic [CNT_W-1:0] cnt);
    logic [WIDTH-1:0] v;
    v = start;
    // EVEN needs bit0 = 0, ODD needs bit0 = 1.
    if (par == 1'b1 && v[0] == 1'b1) v = v + 1'b1;
    if (par == 1'b0 && v[0] == 1'b0) v = v + 1'b1;
    for (int i = 0; i < int'(cnt); i++) begin
      q.push_back('{num: v, last: (i == int'(cnt) - 1)});
      v = v + 4'd2;
    end
    chk("req_ready_accept", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_parity = par;
    req_start  = start;
    req_count  = cnt;
    tick();
    req_valid  = 1'b0;
    req_start  = $urandom_range(0, 15);
    req_count  = $urandom_range(0, 15);
    req_parity = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    xfers      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_parity = 1'b0;
    req_start  = '0;
    req_count  = '0;
    out_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_number", 32'(out_number), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // EVEN from 3: 4 6 8 10, one per cycle
    request(1'b1, 4'd3, 4'd4);
    chk("even_first_valid", 32'(out_valid), 32'd1);
    chk("even_first_num", 32'(out_number), 32'd4);
    xfers = 0;
    drain(10);
    chk("even_xfers", 32'(xfers), 32'd4);
    chk("even_ready_after", 32'(req_ready), 32'd1);
    chk("even_valid_after", 32'(out_valid), 32'd0);

    // ODD from 13 with wrap: 13 15 1
    request(1'b0, 4'd13, 4'd3);
    drain(10);
    chk("odd_ready_after", 32'(req_ready), 32'd1);

    // Backpressure: 0, stall on 2, then 4 last
    request(1'b1, 4'd0, 4'd3);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_num", 32'(out_number), 32'd2);
      chk("stall_last", 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    drain(10);
    chk("bp_ready_after", 32'(req_ready), 32'd1);

    // Zero count emits nothing
    xfers = 0;
    request(1'b0, 4'd5, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_valid", 32'(out_valid), 32'd0);
      chk("zero_ready", 32'(req_ready), 32'd1);
      tick();
    end
    chk("zero_xfers", 32'(xfers), 32'd0);
    request(1'b0, 4'd6, 4'd1);
    chk("single_num", 32'(out_number), 32'd7);
    chk("single_last", 32'(out_last), 32'd1);
    drain(5);

    // Reset mid-burst after 3 transfers
    request(1'b1, 4'd0, 4'd8);
    tick();
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_num", 32'(out_number), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_num", 32'(out_number), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    request(1'b1, 4'd9, 4'd2);
    chk("post_rst_first", 32'(out_number), 32'd10);
    drain(6);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
